// File: rtl/hack_cpu_hs.sv
// Multi-cycle Hack CPU with valid/ready instruction fetch and handshaked data memory.
// Widths are parameterised; C-instruction fields sit at fixed low bits for every WIDTH.
module hack_cpu_hs #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [AW-1:0]    pc,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_wr,
    input  logic             mem_wack,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             halted
);

    typedef enum logic [2:0] {StFetch, StMread, StExec, StMwrite, StHalt} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, d_q, m_q, wdata_q;
    logic [12:0]      ir_q;
    logic [AW-1:0]    pc_q, waddr_q;
    logic             halt_pend_q;

    logic [WIDTH-1:0] alu_x, alu_y, alu_out;
    logic [AW-1:0]    a_tgt, pc_inc;
    logic             zr, ng, jump, self_jump;

    // Hack ALU: c bits 11..6 are zx, nx, zy, ny, f, no.
    always_comb begin
        alu_x = ir_q[11] ? '0 : d_q;
        if (ir_q[10]) alu_x = ~alu_x;
        alu_y = ir_q[12] ? m_q : a_q;
        if (ir_q[9]) alu_y = '0;
        if (ir_q[8]) alu_y = ~alu_y;
        alu_out = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ir_q[6]) alu_out = ~alu_out;
    end

    assign zr        = (alu_out == '0);
    assign ng        = alu_out[WIDTH-1];
    assign jump      = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);
    assign a_tgt     = a_q[AW-1:0];
    assign pc_inc    = pc_q + AW'(1);
    assign self_jump = jump && (a_tgt == pc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFetch;
            a_q         <= '0;
            d_q         <= '0;
            m_q         <= '0;
            wdata_q     <= '0;
            ir_q        <= '0;
            pc_q        <= '0;
            waddr_q     <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (instr_valid) begin
                        if (!instr[WIDTH-1]) begin
                            a_q  <= {1'b0, instr[WIDTH-2:0]};
                            pc_q <= pc_inc;
                        end else begin
                            ir_q    <= instr[12:0];
                            state_q <= instr[12] ? StMread : StExec;
                        end
                    end
                end
                StMread: begin
                    if (mem_rvalid) begin
                        m_q     <= mem_rdata;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (ir_q[4]) d_q <= alu_out;
                    if (ir_q[5]) a_q <= alu_out;
                    pc_q <= jump ? a_tgt : pc_inc;
                    // Write address and jump target both use A as it was before this update.
                    if (ir_q[3]) begin
                        waddr_q     <= a_tgt;
                        wdata_q     <= alu_out;
                        halt_pend_q <= self_jump;
                        state_q     <= StMwrite;
                    end else begin
                        state_q <= self_jump ? StHalt : StFetch;
                    end
                end
                StMwrite: begin
                    if (mem_wack) state_q <= halt_pend_q ? StHalt : StFetch;
                end
                StHalt: begin
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    // Gating with reset forces the handshake outputs low as soon as reset asserts.
    assign instr_ready = reset && (state_q == StFetch);
    assign mem_rd      = reset && (state_q == StMread);
    assign mem_wr      = reset && (state_q == StMwrite);
    assign halted      = reset && (state_q == StHalt);
    assign mem_addr    = (state_q == StMwrite) ? waddr_q : a_q[AW-1:0];
    assign mem_wdata   = wdata_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_hack_cpu_hs.sv
// Directed bench for hack_cpu_hs: a 16-bit core for the handshake programs and a
// 32-bit/20-bit core for wide arithmetic and pc wrap.
module tb_hack_cpu_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] pc, mem_addr, mem_wdata;
    logic        mem_rd, mem_wr, halted;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_wack = 1'b0;

    logic [31:0] instr32 = '0;
    logic        valid32 = 1'b0;
    logic        ready32;
    logic [19:0] pc32, addr32;
    logic        rd32, wr32, halted32;
    logic [31:0] wdata32;
    logic        rvalid32 = 1'b0;
    logic        wack32 = 1'b0;
    logic [31:0] rdata32 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_cpu_hs u_dut16 (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
        .mem_wack(mem_wack), .mem_wdata(mem_wdata), .halted(halted)
    );

    hack_cpu_hs #(.WIDTH(32), .AW(20)) u_dut32 (
        .clk(clk), .reset(reset), .instr(instr32), .instr_valid(valid32),
        .instr_ready(ready32), .pc(pc32), .mem_addr(addr32), .mem_rd(rd32),
        .mem_rvalid(rvalid32), .mem_rdata(rdata32), .mem_wr(wr32),
        .mem_wack(wack32), .mem_wdata(wdata32), .halted(halted32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch(input logic [15:0] w);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("fetch_ready", instr_ready, 1);
        instr = w;
        instr_valid = 1'b1;
        cyc(1);
        instr_valid = 1'b0;
    endtask

    task automatic fetch32(input logic [31:0] w);
        int n = 0;
        while (ready32 !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("fetch32_ready", ready32, 1);
        instr32 = w;
        valid32 = 1'b1;
        cyc(1);
        valid32 = 1'b0;
    endtask

    // Waits for the write, holds mem_wack low for dly cycles, then acknowledges.
    task automatic mwrite(input logic [15:0] ea, input logic [15:0] ed, input int dly);
        int n = 0;
        int hi = 0;
        int bad = 0;
        while (mem_wr !== 1'b1 && n < 10) begin
            cyc(1);
            n++;
        end
        chk("wr_seen", mem_wr, 1);
        for (int i = 0; i <= dly; i++) begin
            if (mem_wr === 1'b1) hi++;
            if (mem_addr !== ea || mem_wdata !== ed || mem_rd !== 1'b0) bad++;
            if (i == dly) mem_wack = 1'b1;
            cyc(1);
        end
        mem_wack = 1'b0;
        chk("wr_cycles", hi, dly + 1);
        chk("wr_stable", bad, 0);
        chk("wr_done", mem_wr, 0);
    endtask

    task automatic mread(input logic [15:0] ea, input logic [15:0] rd, input int dly);
        int n = 0;
        int bad = 0;
        while (mem_rd !== 1'b1 && n < 10) begin
            cyc(1);
            n++;
        end
        chk("rd_seen", mem_rd, 1);
        for (int i = 0; i <= dly; i++) begin
            if (mem_addr !== ea || mem_wr !== 1'b0 || mem_rd !== 1'b1) bad++;
            if (i == dly) begin
                mem_rdata = rd;
                mem_rvalid = 1'b1;
            end
            cyc(1);
        end
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        chk("rd_stable", bad, 0);
        chk("rd_done", mem_rd, 0);
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_ready", instr_ready, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ready32", ready32, 0);
        #2 reset = 1'b1;
        #1 chk("rel_ready", instr_ready, 1);

        // A=5 then D=A, observed through M=D
        fetch(16'h0005);
        chk("a_pc", pc, 1);
        fetch(16'hEC10);
        chk("exec_busy", instr_ready, 0);
        cyc(1);
        chk("c_pc", pc, 2);
        chk("c_ready", instr_ready, 1);
        fetch(16'hE308);
        mwrite(16'h0005, 16'h0005, 0);
        chk("pc3", pc, 3);

        // D=9, A=7, M=D+1 with a delayed acknowledge
        fetch(16'h0009);
        fetch(16'hEC10);
        fetch(16'h0007);
        fetch(16'hE7C8);
        mwrite(16'h0007, 16'h000A, 3);
        chk("pc7", pc, 7);

        // A=3, D=M with slow read returning 0x8000, then M=D;JLT to 0x20
        fetch(16'h0003);
        fetch(16'hFC10);
        mread(16'h0003, 16'h8000, 2);
        fetch(16'h0020);
        chk("pc10", pc, 10);
        fetch(16'hE30C);
        mwrite(16'h0020, 16'h8000, 1);
        chk("jlt_pc", pc, 16'h0020);

        // Jump-to-self halts
        fetch(16'h0021);
        fetch(16'hEA87);
        cyc(1);
        chk("halt_flag", halted, 1);
        chk("halt_ready", instr_ready, 0);
        chk("halt_pc", pc, 16'h0021);
        instr = 16'h0000;
        instr_valid = 1'b1;
        mem_rvalid = 1'b1;
        cyc(3);
        instr_valid = 1'b0;
        mem_rvalid = 1'b0;
        chk("halt_stays", halted, 1);
        chk("halt_pc_hold", pc, 16'h0021);
        chk("halt_rdwr", {mem_rd, mem_wr}, 0);

        // Reset from halt, then reset in the middle of a write
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        #1 chk("rel2_ready", instr_ready, 1);
        chk("rel2_halted", halted, 0);
        fetch(16'h0010);
        fetch(16'hE308);
        cyc(1);
        chk("mw_active", mem_wr, 1);
        #2 reset = 1'b0;
        #1 chk("abort_wr", mem_wr, 0);
        chk("abort_ready", instr_ready, 0);
        chk("abort_pc", pc, 0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        chk("after_abort_ready", instr_ready, 1);
        chk("after_abort_pc", pc, 0);
        chk("after_abort_wr", mem_wr, 0);
        fetch(16'h0002);
        chk("after_abort_run", pc, 1);

        // 32-bit core: D=-1, D=D+1 -> zero, JEQ to 0xFFFFF, then wrap to 0
        fetch32(32'h000F_FFFF);
        fetch32(32'hFFFF_EE90);
        fetch32(32'hFFFF_E7D0);
        fetch32(32'hFFFF_E302);
        cyc(1);
        chk("w32_jeq", pc32, 20'hFFFFF);
        fetch32(32'h0000_0005);
        chk("w32_wrap", pc32, 0);
        chk("w32_addr", addr32, 20'h00005);
        chk("w32_quiet", {rd32, wr32, halted32}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
